clock_tick_divider: RTL
=======================

CLOCK_TICK_DIVIDER -- requirements
Module: clock_tick_divider

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning the divisor width.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the tick_count width.
REQ-003 SHALL have parameter RESET_DIV, default 1, meaning the active and shadow divisor value after reset.
REQ-004 SHALL have port clock  input  1  single clock, driven by the selected clock from the clock source selector.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  run request, level-sensitive.
REQ-007 SHALL have port div_value  input  DIV_W  requested divisor D; tick period is D+1 cycles.
REQ-008 SHALL have port div_load  input  1  one-cycle strobe that captures div_value into the shadow register.
REQ-009 SHALL have port tick  output  1  one-cycle pulse at each terminal count.
REQ-010 SHALL have port clk_div  output  1  divided clock that toggles on every tick.
REQ-011 SHALL have port load_ack  output  1  one-cycle pulse when a captured divisor becomes active.
REQ-012 SHALL have port tick_count  output  CNT_W  running count of ticks.
REQ-013 SHALL have port running  output  1  high while in state RUN.
REQ-014 SHALL register all outputs; no output has a combinational path from any input.

Function
REQ-015 SHALL implement two states, IDLE and RUN, plus a pending flag.
REQ-016 In IDLE, the counter SHALL be held at 0; tick, clk_div and running SHALL be 0; tick_count SHALL hold its value.
REQ-017 IDLE -> RUN SHALL occur on the edge enable is sampled high; that edge sets counter = 0 and running = 1.
REQ-018 In RUN, the counter SHALL increment each edge.
REQ-019 In RUN, on the edge where counter == active_div: counter -> 0, tick -> 1 for one cycle, clk_div toggles, tick_count increments.
REQ-020 First tick SHALL be high after edge E0+(D+1), where E0 is the RUN-entry edge; subsequent ticks SHALL occur every D+1 edges.
REQ-021 With active_div = 0, tick SHALL be high every cycle and clk_div SHALL toggle every cycle.
REQ-022 tick_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-023 A div_load sampled high SHALL write div_value to shadow and set pending.
REQ-024 A later div_load while pending SHALL overwrite shadow; only one load_ack SHALL result.
REQ-025 In RUN, a pending shadow SHALL transfer to active_div only on a terminal-count edge; load_ack SHALL be high in the same cycle as that tick, and pending SHALL clear.
REQ-026 A div_load sampled on the same edge as a terminal count SHALL be applied at that boundary, so the next period uses the new value, with load_ack coincident with the tick.
REQ-027 In IDLE, a pending shadow SHALL transfer to active_div on the next edge, with load_ack high for one cycle.
REQ-028 A div_load and enable rise sampled on the same edge SHALL make the new value govern the first period; load_ack SHALL pulse once.
REQ-029 enable sampled low in RUN SHALL cause RUN -> IDLE on that edge: counter 0, clk_div 0, tick 0, running 0.
REQ-030 If enable falls while pending, the pending value SHALL be applied per REQ-027.
REQ-031 The divisor SHALL never change mid-period; a period always completes with the active_div value present at its start.

Reset
REQ-032 While reset_n is low, the block SHALL immediately, without a clock, force: state IDLE, counter 0, pending 0, tick 0, clk_div 0, load_ack 0, tick_count 0, running 0, active_div = shadow = RESET_DIV.
REQ-033 Reset deassertion SHALL take effect synchronously on the first clock edge after reset_n rises.
REQ-034 Reset asserted mid-period SHALL abort the period; no tick or load_ack SHALL follow it.

Verification
REQ-035 Reset, then enable=1 with defaults -> tick high every 2 cycles, clk_div period 4 cycles, first tick 2 edges after RUN entry.
REQ-036 div_load with div_value=3 in IDLE, then enable=1 -> load_ack one cycle after the load; ticks every 4 cycles; tick_count = 5 after 20 cycles.
REQ-037 Running with D=3, div_load D=0 mid-period -> current period still 4 cycles; load_ack with that tick; then tick every cycle.
REQ-038 Two div_loads (D=7, then D=2) within one D=5 period -> one load_ack; next period 3 cycles.
REQ-039 D=0 for 256 cycles -> tick_count wraps 255 -> 0; clk_div toggles every cycle.
REQ-040 reset_n low mid-period with pending set -> all outputs 0 immediately without a clock; after release, divisor = RESET_DIV and no load_ack.

Source files
------------

// File: rtl/clock_tick_divider.sv
// Programmable tick generator: emits a one-cycle tick every active_div+1 clocks, a toggling
// divided clock, and a running tick count. New divisors are staged in a shadow register.
module clock_tick_divider #(
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_div,
  output logic             load_ack,
  output logic [CNT_W-1:0] tick_count,
  output logic             running
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [DIV_W-1:0] counter_r;
  logic [DIV_W-1:0] active_div_r;
  logic [DIV_W-1:0] shadow_r;
  logic             pending_r;

  logic [DIV_W-1:0] counter_nxt_s;
  logic [DIV_W-1:0] active_div_nxt_s;
  logic [DIV_W-1:0] shadow_nxt_s;
  logic             pending_nxt_s;
  logic             tick_nxt_s;
  logic             clk_div_nxt_s;
  logic             load_ack_nxt_s;
  logic [CNT_W-1:0] tick_count_nxt_s;
  logic             running_nxt_s;

  // A load strobe on this edge is folded into the staged value so it can be applied at once.
  logic             pend_eff_s;
  logic [DIV_W-1:0] shadow_eff_s;

  assign pend_eff_s   = pending_r | div_load;
  assign shadow_eff_s = div_load ? div_value : shadow_r;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: enable alone moves between IDLE and RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (enable) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the counter, divisor staging and every registered output
  always_comb begin
    counter_nxt_s    = {DIV_W{1'b0}};
    active_div_nxt_s = active_div_r;
    shadow_nxt_s     = shadow_eff_s;
    pending_nxt_s    = pend_eff_s;
    tick_nxt_s       = 1'b0;
    clk_div_nxt_s    = 1'b0;
    load_ack_nxt_s   = 1'b0;
    tick_count_nxt_s = tick_count;
    case (state_r)
      IDLE: begin
        if (pend_eff_s) begin
          active_div_nxt_s = shadow_eff_s;
          pending_nxt_s    = 1'b0;
          load_ack_nxt_s   = 1'b1;
        end else begin
          active_div_nxt_s = active_div_r;
          pending_nxt_s    = 1'b0;
          load_ack_nxt_s   = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          counter_nxt_s = {DIV_W{1'b0}};
          clk_div_nxt_s = 1'b0;
        end else if (counter_r == active_div_r) begin
          // Terminal count: the only point where a staged divisor may take over
          tick_nxt_s       = 1'b1;
          clk_div_nxt_s    = ~clk_div;
          tick_count_nxt_s = tick_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (pend_eff_s) begin
            active_div_nxt_s = shadow_eff_s;
            pending_nxt_s    = 1'b0;
            load_ack_nxt_s   = 1'b1;
          end else begin
            active_div_nxt_s = active_div_r;
            pending_nxt_s    = 1'b0;
            load_ack_nxt_s   = 1'b0;
          end
        end else begin
          counter_nxt_s = counter_r + {{(DIV_W-1){1'b0}}, 1'b1};
          clk_div_nxt_s = clk_div;
        end
      end
      default: begin
        counter_nxt_s = {DIV_W{1'b0}};
        pending_nxt_s = 1'b0;
      end
    endcase
    running_nxt_s = (state_nxt_s == RUN);
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_r    <= {DIV_W{1'b0}};
      active_div_r <= DIV_W'(RESET_DIV);
      shadow_r     <= DIV_W'(RESET_DIV);
      pending_r    <= 1'b0;
      tick         <= 1'b0;
      clk_div      <= 1'b0;
      load_ack     <= 1'b0;
      tick_count   <= {CNT_W{1'b0}};
      running      <= 1'b0;
    end else begin
      counter_r    <= counter_nxt_s;
      active_div_r <= active_div_nxt_s;
      shadow_r     <= shadow_nxt_s;
      pending_r    <= pending_nxt_s;
      tick         <= tick_nxt_s;
      clk_div      <= clk_div_nxt_s;
      load_ack     <= load_ack_nxt_s;
      tick_count   <= tick_count_nxt_s;
      running      <= running_nxt_s;
    end
  end

endmodule
